storage_arbiter: RTL and testbench
==================================

STORAGE_ARBITER -- requirements
Module: storage_arbiter

Parameters
REQ-001 WIDTH, 8, bit width of the shared storage register.
REQ-002 N_REQ, 4, number of requesters; fixed at 4 for this release.

Interface
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low; synchronous deassert handled upstream.
REQ-005 req  input  N_REQ  per-requester request level; held high until matching ack.
REQ-006 op  input  2*N_REQ  per-requester opcode, slice i = op[2i+1:2i]: 00 WRITE, 01 PRESET, 10 CLEAR, 11 NOP.
REQ-007 wdata  input  WIDTH*N_REQ  per-requester write data, slice i = wdata[WIDTH*i +: WIDTH].
REQ-008 gnt  output  N_REQ  one-hot grant, registered.
REQ-009 ack  output  N_REQ  one-hot, one-cycle completion pulse, registered.
REQ-010 busy  output  1  high whenever FSM is not IDLE.
REQ-011 q  output  WIDTH  current shared register contents.

Function
REQ-012 FSM states: IDLE, GRANT, ACK; encoding in shared package.
REQ-013 IDLE: if |req at rising edge, SHALL select winner by round-robin, latch winner's op and wdata, set gnt[winner], go GRANT; else stay IDLE.
REQ-014 Round-robin: search starts at pointer ptr, ascending index mod N_REQ; first asserted req wins.
REQ-015 GRANT: one cycle; at its closing edge register SHALL update per latched op: WRITE q<=wdata, PRESET q<=all ones, CLEAR q<=all zeros, NOP q unchanged; go ACK.
REQ-016 ACK: ack[winner]=1 for exactly this cycle, gnt=0, ptr<=(winner+1) mod N_REQ; next state IDLE.
REQ-017 Latency: req sampled at edge k -> gnt high in cycle k+1, q valid and ack high in cycle k+2, IDLE in cycle k+3; minimum 3 cycles per transaction.
REQ-018 Op and wdata are latched at grant; changes on inputs after grant SHALL NOT affect the transaction.
REQ-019 req dropped during GRANT: transaction still commits and acks.
REQ-020 Requester still high in cycle after its ack SHALL be treated as a new request, subject to round-robin.
REQ-021 Simultaneous requests: exactly one granted per transaction; no requester starved beyond N_REQ-1 intervening transactions.
REQ-022 gnt and ack SHALL be one-hot or zero at all times; never both nonzero in the same cycle.
REQ-023 ptr wrap: winner 3 -> ptr 0.

Reset
REQ-024 rst_n low SHALL immediately force: state IDLE, q=0, gnt=0, ack=0, busy=0, ptr=0, latched op/data=0.
REQ-025 Reset during GRANT or ACK aborts the transaction with no ack; the requester SHALL re-request.
REQ-026 First edge after rst_n rises evaluates IDLE normally.

Structure
REQ-027 Shared package: opcode constants (OP_WRITE, OP_PRESET, OP_CLEAR, OP_NOP), FSM state type/encoding, default WIDTH and N_REQ.
REQ-028 One sub-module, storage_cell: WIDTH-bit register with async active-low reset, synchronous en, preset, clear, d; priority clear > preset > d; arbiter drives exactly one control per transaction.
REQ-029 Round-robin selection is combinational logic inside storage_arbiter; no further hierarchy.

Verification
REQ-030 Reset, then req[2]=1 op=WRITE wdata=0xA5 -> gnt=0100 next cycle, q=0xA5 and ack=0100 the cycle after, busy low after.
REQ-031 All four req high, ops WRITE 0x11/0x22/0x33/0x44 held -> grant order 0,1,2,3,0; q sequence 0x11,0x22,0x33,0x44; ack one-hot each.
REQ-032 q=0x3C, req[1] PRESET then req[3] CLEAR -> q=0xFF then q=0x00; req[0] NOP -> q unchanged, ack=0001.
REQ-033 Grant req[0] WRITE 0x5A, change wdata to 0xFF and drop req in GRANT -> q=0x5A, ack=0001.
REQ-034 rst_n low mid-GRANT -> q=0, gnt=0, no ack; after release and re-request, grant goes to lowest-index requester (ptr=0).

Source files
------------

// File: rtl/storage_arbiter_pkg.sv
// Shared types and constants for the storage arbiter slice.
package storage_arbiter_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_N_REQ = 4;

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_PRESET = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_NOP    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GRANT = 2'b01,
    ST_ACK   = 2'b10
  } state_t;

endpackage

// File: rtl/storage_cell.sv
// Shared register: clear > preset > load; updates on the edge its control is high.
// No handshake; the arbiter asserts at most one control per transaction.
module storage_cell
  import storage_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             preset,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      q <= '0;
    else if (clear)  q <= '0;
    else if (preset) q <= '1;
    else if (en)     q <= d;
  end

endmodule

// File: rtl/storage_arbiter.sv
// Round-robin arbiter granting one requester access to a shared register; 3 cycles/transaction.
// Requesters hold req until ack; losers simply wait, no queueing beyond the req level.
module storage_arbiter
  import storage_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N_REQ = DEF_N_REQ
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [2*N_REQ-1:0]     op,
  input  logic [WIDTH*N_REQ-1:0] wdata,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       ack,
  output logic                   busy,
  output logic [WIDTH-1:0]       q
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    winner;
  logic [PW-1:0]    ptr_nxt;
  logic [1:0]       lat_op;
  logic [WIDTH-1:0] lat_dat;
  logic             sel_vld;
  logic [PW-1:0]    sel_idx;
  logic [PW:0]      cand;
  logic             cell_en;
  logic             cell_preset;
  logic             cell_clear;

  // Scan from ptr upward with wrap; first asserted request wins.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, ptr} + (PW+1)'(i);
      if (cand >= (PW+1)'(N_REQ)) cand = cand - (PW+1)'(N_REQ);
      if (!sel_vld && req[cand[PW-1:0]]) begin
        sel_vld = 1'b1;
        sel_idx = cand[PW-1:0];
      end
    end
  end

  assign ptr_nxt = (winner == PW'(N_REQ-1)) ? '0 : winner + 1'b1;
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      winner  <= '0;
      lat_op  <= '0;
      lat_dat <= '0;
      gnt     <= '0;
      ack     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sel_vld) begin
            winner       <= sel_idx;
            lat_op       <= op[2*int'(sel_idx) +: 2];
            lat_dat      <= wdata[WIDTH*int'(sel_idx) +: WIDTH];
            gnt[sel_idx] <= 1'b1;
            state        <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          gnt         <= '0;
          ack[winner] <= 1'b1;
          state       <= ST_ACK;
        end
        ST_ACK: begin
          ack   <= '0;
          ptr   <= ptr_nxt;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The register commits on the edge that closes GRANT, so q is new during ACK.
  assign cell_en     = (state == ST_GRANT) && (lat_op == OP_WRITE);
  assign cell_preset = (state == ST_GRANT) && (lat_op == OP_PRESET);
  assign cell_clear  = (state == ST_GRANT) && (lat_op == OP_CLEAR);

  storage_cell #(.WIDTH(WIDTH)) u_cell (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (cell_en),
    .preset (cell_preset),
    .clear  (cell_clear),
    .d      (lat_dat),
    .q      (q)
  );

endmodule

// File: tb/tb_storage_arbiter.sv
// Scenario tasks plus randomized transactions checked against a transaction-level model.
module tb_storage_arbiter;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [2*N-1:0] op = '0;
  logic [W*N-1:0] wdata = '0;
  logic [N-1:0]   gnt;
  logic [N-1:0]   ack;
  logic           busy;
  logic [W-1:0]   q;

  int checks = 0;
  int failures = 0;

  int         m_ptr;
  logic [W-1:0] m_q;

  storage_arbiter #(.WIDTH(W), .N_REQ(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .op    (op),
    .wdata (wdata),
    .gnt   (gnt),
    .ack   (ack),
    .busy  (busy),
    .q     (q)
  );

  always #5 clk = ~clk;

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [W-1:0] apply_op(input logic [W-1:0] cur, input logic [1:0] o,
                                            input logic [W-1:0] d);
    case (o)
      2'b00:   return d;
      2'b01:   return '1;
      2'b10:   return '0;
      default: return cur;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut;
    rst_n = 1'b0;
    req = '0;
    op = '0;
    wdata = '0;
    tick;
    tick;
    rst_n = 1'b1;
    m_ptr = 0;
    m_q = '0;
  endtask

  task automatic do_txn(input string name, input logic [N-1:0] r, input logic [2*N-1:0] o,
                        input logic [W*N-1:0] d, input bit perturb, input bit hold);
    int w;
    logic [N-1:0] exp_oh;
    logic [W-1:0] exp_q;
    req = r;
    op = o;
    wdata = d;
    w = rr_pick(r, m_ptr);
    exp_oh = '0;
    exp_oh[w] = 1'b1;
    exp_q = apply_op(m_q, o[2*w +: 2], d[W*w +: W]);
    tick;
    checks++;
    if (gnt !== exp_oh || ack !== '0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL %s_grant: gnt=%b ack=%b busy=%b, required gnt=%b ack=0000 busy=1",
               name, gnt, ack, busy, exp_oh);
    end
    if (perturb) begin
      wdata = ~d;
      op = ~o;
      req[w] = 1'b0;
    end
    tick;
    checks++;
    if (ack !== exp_oh || gnt !== '0 || q !== exp_q) begin
      failures++;
      $display("FAIL %s_ack: ack=%b gnt=%b q=%h, required ack=%b gnt=0000 q=%h",
               name, ack, gnt, q, exp_oh, exp_q);
    end
    m_q = exp_q;
    m_ptr = (w + 1) % N;
    if (!hold) req = '0;
    tick;
    checks++;
    if (busy !== 1'b0 || ack !== '0 || gnt !== '0 || q !== exp_q) begin
      failures++;
      $display("FAIL %s_idle: busy=%b ack=%b gnt=%b q=%h, required busy=0 ack=0000 gnt=0000 q=%h",
               name, busy, ack, gnt, q, exp_q);
    end
  endtask

  task automatic test_reset;
    reset_dut;
    checks++;
    if (q !== '0 || gnt !== '0 || ack !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset: q=%h gnt=%b ack=%b busy=%b, required all zero", q, gnt, ack, busy);
    end
    tick;
    checks++;
    if (gnt !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: gnt=%b busy=%b, required 0000 and 0", gnt, busy);
    end
  endtask

  task automatic test_single_write;
    reset_dut;
    do_txn("single", 4'b0100, 8'h00, 32'h00A5_0000, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    reset_dut;
    for (int t = 0; t < 5; t++)
      do_txn("rr", 4'b1111, 8'h00, 32'h4433_2211, 1'b0, 1'b1);
  endtask

  task automatic test_ops;
    reset_dut;
    do_txn("ops_wr", 4'b0001, 8'h00, 32'h0000_003C, 1'b0, 1'b0);
    do_txn("ops_preset", 4'b0010, 8'h04, 32'h0000_0000, 1'b0, 1'b0);
    do_txn("ops_clear", 4'b1000, 8'h80, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_txn("ops_wr2", 4'b0100, 8'h00, 32'h0066_0000, 1'b0, 1'b0);
    do_txn("ops_nop", 4'b0001, 8'h03, 32'h0000_00EE, 1'b0, 1'b0);
  endtask

  task automatic test_latch;
    reset_dut;
    do_txn("latch", 4'b0001, 8'h00, 32'h0000_005A, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid;
    reset_dut;
    do_txn("rm_setup", 4'b0010, 8'h00, 32'h0000_7700, 1'b0, 1'b0);
    req = 4'b1000;
    wdata = 32'h1200_0000;
    tick;
    checks++;
    if (gnt !== 4'b1000 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rm_grant: gnt=%b busy=%b, required 1000 and 1", gnt, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (q !== '0 || gnt !== '0 || ack !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rm_abort: q=%h gnt=%b ack=%b busy=%b, required all zero", q, gnt, ack, busy);
    end
    tick;
    checks++;
    if (ack !== '0 || gnt !== '0) begin
      failures++;
      $display("FAIL rm_noack: ack=%b gnt=%b, required 0000 0000", ack, gnt);
    end
    rst_n = 1'b1;
    m_ptr = 0;
    m_q = '0;
    do_txn("rm_rereq", 4'b1010, 8'h00, 32'h0000_9900, 1'b0, 1'b0);
  endtask

  task automatic test_random;
    logic [N-1:0]   r;
    logic [2*N-1:0] o;
    logic [W*N-1:0] d;
    reset_dut;
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 4) == 0) begin
        req = '0;
        tick;
        checks++;
        if (gnt !== '0 || busy !== 1'b0 || ack !== '0) begin
          failures++;
          $display("FAIL rand_gap: gnt=%b busy=%b ack=%b, required idle", gnt, busy, ack);
        end
      end
      r = N'($urandom_range(1, 15));
      o = 8'($urandom);
      d = $urandom;
      do_txn("rand", r, o, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset;
    test_single_write;
    test_back_to_back;
    test_ops;
    test_latch;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
